bandai_so_receiver: RTL and testbench
=====================================

Name: bandai_so_receiver

Overview:
- Console-side receiver that consumes the synchronous serial line SO driven by the Bandai 2003 mapper after its unlock sequence completes.
- Deserialises the frame, validates it against a key, and presents the 16-bit word, a strobe, a frame-error strobe, a sticky UNLOCK flag and a frame counter to the system-control model.
- Sits directly downstream of the mapper's SO pin and runs on the same CLK, so no synchroniser is used.

Parameters:
- KEY, 16'h28A0, expected payload; a valid frame equal to KEY sets UNLOCK.
- CNT_W, 4, width of the saturating frame counter.

Ports:
- CLK  input  1  clock; all sampling on rising edge.
- RSTn  input  1  reset, asynchronous, active-low.
- SI  input  1  serial line from mapper SO; board pull-up; Z during mapper reset reads as 1.
- DATA  output  16  last successfully received payload.
- VALID  output  1  one-cycle strobe: DATA updated with a good frame.
- FERR  output  1  one-cycle strobe: framing error, DATA unchanged.
- UNLOCK  output  1  sticky; set by a good frame whose payload equals KEY.
- FRAMES  output  CNT_W  count of good frames, saturating at all-ones.
- BUSY  output  1  high while in DATA or END state.

Behaviour:
- Reset (RSTn low, async): state=IDLE; DATA=16'h0000; VALID=0; FERR=0; UNLOCK=0; FRAMES=0; bit counter=0; shift reg=0. Reset mid-frame aborts the frame with no strobe.
- Frame format on SI, one bit per CLK: start bit 0, then 16 payload bits LSB first, then end bit 0, then idle 1s.
- State machine:
  - IDLE: SI=1 -> stay. SI=0 -> DATA, with bit counter cleared.
  - DATA: shift SI into bit[cnt], cnt+1; after 16th bit -> END.
  - END: SI=0 -> good frame, go to RECOVER. SI=1 -> framing error, go to IDLE.
  - RECOVER: stay while SI=0; SI=1 -> IDLE.
- RECOVER blocks a stuck-low line from being taken as back-to-back frames.
- Timing: start sampled at edge N; payload bits at edges N+1..N+16; end bit at edge N+17.
- Outputs are registered at edge N+17 and visible for exactly one cycle after it:
  - Good frame: DATA, VALID=1, FRAMES+1 (saturating); UNLOCK set if payload==KEY.
  - Bad end bit: FERR=1 only.
- VALID and FERR are never high together. Both return to 0 on the following edge.
- UNLOCK is cleared only by RSTn. A later non-matching good frame updates DATA but does not clear UNLOCK.
- BUSY=1 in DATA and END; 0 in IDLE and RECOVER.
- SI=0 in IDLE exactly one edge after RECOVER exits counts as a new start bit; the minimum idle gap between frames is 1 cycle.
- Payload assembly: bit k of DATA = SI sampled at edge N+1+k.

Test Plan:
- Reset release, mapper model emits 0,16'h28A0 LSB-first,0 then 1s -> VALID one cycle at N+17, DATA=16'h28A0, UNLOCK=1, FRAMES=1, FERR never high.
- Frame 0,16'h1234,1 (bad end bit) -> FERR one cycle, DATA=0000, UNLOCK=0, FRAMES=0, state returns to IDLE.
- Good frame 16'hBEEF after an unlock frame -> DATA=16'hBEEF, UNLOCK stays 1, FRAMES=2.
- SI held 0 for 40 cycles after reset -> one frame with DATA=16'h0000 and VALID=1, then RECOVER holds with no further strobes; SI->1 then a valid KEY frame -> UNLOCK=1, FRAMES=2.
- RSTn pulsed low at payload bit 8 of a KEY frame -> all outputs 0 immediately and no strobe; SI idle 1 afterward -> stays IDLE.
- 20 back-to-back good frames, each separated by one idle 1 -> FRAMES saturates at 4'hF and VALID fires 20 times.

Source files
------------

// File: rtl/bandai_so_receiver.sv
// Console-side receiver for the Bandai 2003 mapper SO line.
// Each frame is a 0 start bit, 16 payload bits sent LSB first, and a 0 end bit.
// The line idles high. A good frame updates DATA and pulses VALID. A good frame
// whose payload equals KEY also sets the sticky UNLOCK flag. A frame whose end
// bit is 1 pulses FERR and leaves DATA unchanged.
// SI comes straight from the mapper, which runs on this same CLK, so SI is
// sampled without a synchroniser.
module bandai_so_receiver #(
  parameter logic [15:0] KEY   = 16'h28A0,
  parameter int          CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             SI,
  output logic [15:0]      DATA,
  output logic             VALID,
  output logic             FERR,
  output logic             UNLOCK,
  output logic [CNT_W-1:0] FRAMES,
  output logic             BUSY
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DATA    = 2'd1;
  localparam logic [1:0] ST_END     = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  localparam logic [CNT_W-1:0] FRAMES_MAX = '1;

  logic [1:0]       state_q,  state_d;
  logic [3:0]       cnt_q,    cnt_d;
  logic [15:0]      shift_q,  shift_d;
  logic [15:0]      data_q,   data_d;
  logic             valid_q,  valid_d;
  logic             ferr_q,   ferr_d;
  logic             unlock_q, unlock_d;
  logic [CNT_W-1:0] frames_q, frames_d;

  // Next-state logic for the frame FSM, the deserialiser and the result registers.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. Without the
    // defaults, a branch that does not assign a signal would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    unlock_d = unlock_q;
    frames_d = frames_q;

    case (state_q)
      ST_IDLE: begin
        if (!SI) begin
          state_d = ST_DATA;
          cnt_d   = 4'd0;
        end
      end

      ST_DATA: begin
        // Bits arrive LSB first. Shifting in at the top places the first
        // payload bit in bit 0 once all 16 bits have been received.
        shift_d = {SI, shift_q[15:1]};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = ST_END;
        end
      end

      ST_END: begin
        if (!SI) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          if (shift_q == KEY) begin
            unlock_d = 1'b1;
          end
          if (frames_q != FRAMES_MAX) begin
            frames_d = frames_q + CNT_W'(1);
          end
          state_d = ST_RECOVER;
        end else begin
          ferr_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_RECOVER: begin
        // A line stuck low must not be read as a series of back-to-back
        // frames. Stay here until the line returns to 1.
        if (SI) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers, cleared by the asynchronous reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      shift_q  <= 16'h0000;
      data_q   <= 16'h0000;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      unlock_q <= 1'b0;
      frames_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then loads its value from the same pre-edge snapshot.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      unlock_q <= unlock_d;
      frames_q <= frames_d;
    end
  end

  assign DATA   = data_q;
  assign VALID  = valid_q;
  assign FERR   = ferr_q;
  assign UNLOCK = unlock_q;
  assign FRAMES = frames_q;
  assign BUSY   = (state_q == ST_DATA) || (state_q == ST_END);

endmodule

// File: tb/tb_bandai_so_receiver.sv
// Directed bench for bandai_so_receiver.
// SI is driven one cycle per bit, just after each rising edge. Outputs are
// sampled 1 time unit after the rising edge that produced them.
module tb_bandai_so_receiver;

  localparam logic [15:0] KEY = 16'h28A0;

  logic        clk;
  logic        rst_n;
  logic        si;
  logic [15:0] data;
  logic        valid;
  logic        ferr;
  logic        unlock;
  logic [3:0]  frames;
  logic        busy;

  int checks;
  int errors;
  int valid_seen;
  int ferr_seen;

  bandai_so_receiver #(.KEY(KEY), .CNT_W(4)) dut (
    .CLK    (clk),
    .RSTn   (rst_n),
    .SI     (si),
    .DATA   (data),
    .VALID  (valid),
    .FERR   (ferr),
    .UNLOCK (unlock),
    .FRAMES (frames),
    .BUSY   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Count the strobes. Flag any cycle in which VALID and FERR are high together.
  always @(negedge clk) begin
    if (valid) valid_seen++;
    if (ferr)  ferr_seen++;
    if (valid || ferr) check("strobe_excl", {31'd0, valid & ferr}, 32'd0);
  end

  // Drive one bit, let the DUT sample it, then settle just past the edge.
  task automatic tick(input logic b);
    si = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  // Drive a start bit and 16 payload bits, LSB first.
  task automatic send_payload(input logic [15:0] d);
    tick(1'b0);
    for (int k = 0; k < 16; k++) tick(d[k]);
    check("busy_before_end", {31'd0, busy}, 32'd1);
    check("no_valid_early", {31'd0, valid}, 32'd0);
  endtask

  task automatic apply_reset;
    si    = 1'b1;
    rst_n = 1'b0;
    #3;
    check("rst_data",   {16'd0, data},   32'd0);
    check("rst_valid",  {31'd0, valid},  32'd0);
    check("rst_ferr",   {31'd0, ferr},   32'd0);
    check("rst_unlock", {31'd0, unlock}, 32'd0);
    check("rst_frames", {28'd0, frames}, 32'd0);
    check("rst_busy",   {31'd0, busy},   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  int v0;
  int f0;

  initial begin
    checks     = 0;
    errors     = 0;
    valid_seen = 0;
    ferr_seen  = 0;
    si         = 1'b1;
    rst_n      = 1'b0;

    // 1: KEY frame after reset.
    apply_reset();
    v0 = valid_seen; f0 = ferr_seen;
    send_payload(KEY);
    tick(1'b0);
    check("t1_valid",  {31'd0, valid},  32'd1);
    check("t1_ferr",   {31'd0, ferr},   32'd0);
    check("t1_data",   {16'd0, data},   32'h28A0);
    check("t1_unlock", {31'd0, unlock}, 32'd1);
    check("t1_frames", {28'd0, frames}, 32'd1);
    check("t1_busy",   {31'd0, busy},   32'd0);
    tick(1'b1);
    check("t1_valid_drop", {31'd0, valid}, 32'd0);
    idle(3);
    check("t1_valid_cnt", valid_seen - v0, 32'd1);
    check("t1_ferr_cnt",  ferr_seen - f0,  32'd0);

    // 2: end bit of 1 gives a framing error.
    apply_reset();
    send_payload(16'h1234);
    tick(1'b1);
    check("t2_ferr",   {31'd0, ferr},   32'd1);
    check("t2_valid",  {31'd0, valid},  32'd0);
    check("t2_data",   {16'd0, data},   32'h0000);
    check("t2_unlock", {31'd0, unlock}, 32'd0);
    check("t2_frames", {28'd0, frames}, 32'd0);
    check("t2_busy",   {31'd0, busy},   32'd0);
    tick(1'b1);
    check("t2_ferr_drop", {31'd0, ferr}, 32'd0);
    check("t2_idle",      {31'd0, busy}, 32'd0);

    // 3: a non-matching frame after KEY leaves UNLOCK set.
    apply_reset();
    send_payload(KEY);
    tick(1'b0);
    tick(1'b1);
    send_payload(16'hBEEF);
    tick(1'b0);
    check("t3_valid",  {31'd0, valid},  32'd1);
    check("t3_data",   {16'd0, data},   32'hBEEF);
    check("t3_unlock", {31'd0, unlock}, 32'd1);
    check("t3_frames", {28'd0, frames}, 32'd2);
    tick(1'b1);

    // 4: line held low for 40 cycles.
    apply_reset();
    v0 = valid_seen;
    for (int i = 0; i < 40; i++) tick(1'b0);
    check("t4_valid_cnt", valid_seen - v0, 32'd1);
    check("t4_data",      {16'd0, data},   32'h0000);
    check("t4_frames",    {28'd0, frames}, 32'd1);
    check("t4_recover",   {31'd0, busy},   32'd0);
    tick(1'b1);
    send_payload(KEY);
    tick(1'b0);
    check("t4_unlock", {31'd0, unlock}, 32'd1);
    check("t4_frames2", {28'd0, frames}, 32'd2);
    tick(1'b1);

    // 5: reset during payload bit 8 aborts the frame.
    apply_reset();
    send_payload(KEY);
    tick(1'b0);
    tick(1'b1);
    v0 = valid_seen; f0 = ferr_seen;
    tick(1'b0);
    for (int k = 0; k < 8; k++) tick(KEY[k]);
    check("t5_busy_mid", {31'd0, busy}, 32'd1);
    si = KEY[8];
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_data",   {16'd0, data},   32'd0);
    check("t5_unlock", {31'd0, unlock}, 32'd0);
    check("t5_frames", {28'd0, frames}, 32'd0);
    check("t5_valid",  {31'd0, valid},  32'd0);
    check("t5_busy",   {31'd0, busy},   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(20);
    check("t5_busy_after", {31'd0, busy}, 32'd0);
    check("t5_no_valid",   valid_seen - v0, 32'd0);
    check("t5_no_ferr",    ferr_seen - f0,  32'd0);

    // 6: 20 frames separated by a single idle bit; FRAMES saturates at 4'hF.
    apply_reset();
    v0 = valid_seen;
    for (int i = 0; i < 20; i++) begin
      logic [15:0] d;
      d = 16'(i * 16'h1111 + 16'h0102);
      send_payload(d);
      tick(1'b0);
      check("t6_valid",  {31'd0, valid},  32'd1);
      check("t6_data",   {16'd0, data},   {16'd0, d});
      check("t6_frames", {28'd0, frames}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      tick(1'b1);
    end
    check("t6_valid_cnt", valid_seen - v0, 32'd20);
    check("t6_sat",       {28'd0, frames}, 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
